// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot loader.
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready; byte_ready never depends on byte_valid.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata, cpu_hold, done, error
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses [N hi][N lo][N*4 data bytes][xor checksum] into instruction-memory writes
// and holds the CPU in reset until a load completes with a good checksum.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  imem_loader_if.slave io_bus,
  output logic [2:0]   o_state
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]        r_state;
  logic [1:0]        r_bcnt;
  logic [15:0]       r_n;
  logic [16:0]       r_idx;
  logic [31:0]       r_word;
  logic [7:0]        r_csum;
  logic [ADDR_W-1:0] r_im_addr;
  logic [31:0]       r_im_wdata;

  logic        w_ready;
  logic        w_hs;
  logic [15:0] w_n_full;
  logic [16:0] w_cap;
  logic [16:0] w_idx_next;
  logic [31:0] w_word_next;

  assign w_ready     = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CHK);
  assign w_hs        = io_bus.byte_valid && w_ready;
  assign w_n_full    = {r_n[15:8], io_bus.byte_data};
  assign w_cap       = 17'd1 << ADDR_W;
  assign w_idx_next  = r_idx + 17'd1;
  assign w_word_next = {r_word[23:0], io_bus.byte_data};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_bcnt     <= '0;
      r_n        <= '0;
      r_idx      <= '0;
      r_word     <= '0;
      r_csum     <= '0;
      r_im_addr  <= '0;
      r_im_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (io_bus.start) begin
            r_state <= S_HDR;
            r_bcnt  <= '0;
            r_idx   <= '0;
            r_csum  <= '0;
          end
        end
        S_HDR: begin
          if (w_hs) begin
            if (r_bcnt == 2'd0) begin
              r_n[15:8] <= io_bus.byte_data;
              r_bcnt    <= 2'd1;
            end else begin
              r_n[7:0] <= io_bus.byte_data;
              r_bcnt   <= 2'd0;
              // A count larger than the memory is rejected before any write can happen.
              if (w_n_full == 16'd0)               r_state <= S_CHK;
              else if ({1'b0, w_n_full} > w_cap)   r_state <= S_ERR;
              else                                 r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_hs) begin
            r_word <= w_word_next;
            r_csum <= r_csum ^ io_bus.byte_data;
            if (r_bcnt == 2'd3) begin
              r_bcnt     <= 2'd0;
              r_im_addr  <= r_idx[ADDR_W-1:0];
              r_im_wdata <= w_word_next;
              r_state    <= S_WRITE;
            end else begin
              r_bcnt <= r_bcnt + 2'd1;
            end
          end
        end
        S_WRITE: begin
          r_idx   <= w_idx_next;
          r_state <= (w_idx_next == {1'b0, r_n}) ? S_CHK : S_DATA;
        end
        S_CHK: begin
          if (w_hs) r_state <= (io_bus.byte_data == r_csum) ? S_DONE : S_ERR;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.byte_ready = w_ready;
  assign io_bus.im_we      = (r_state == S_WRITE);
  assign io_bus.im_addr    = r_im_addr;
  assign io_bus.im_wdata   = r_im_wdata;
  assign io_bus.cpu_hold   = (r_state != S_DONE);
  assign io_bus.done       = (r_state == S_DONE);
  assign io_bus.error      = (r_state == S_ERR);
  assign o_state           = r_state;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven randomized loads against a stream-level
// reference model, plus fixed corner-case sequences (bad length, empty load, mid-load reset).
module tb_imem_loader;
  localparam int ADDR_W = 10;
  localparam int CAP    = 1 << ADDR_W;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int n;
    bit bad;
    int max_gap;
    bit exp_done;
    bit exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus),
    .o_state(state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: expected writes {addr, data}
  logic [ADDR_W+31:0] exp_q[$];

  // Monitor, sampled on the falling edge
  logic [ADDR_W+31:0] wr_log[$];
  int   hs_count        = 0;
  int   we_ready_viol   = 0;
  int   we_latency_viol = 0;
  logic prev_hs         = 1'b0;

  always @(negedge clk) begin
    if (bus.im_we) begin
      wr_log.push_back({bus.im_addr, bus.im_wdata});
      if (bus.byte_ready) we_ready_viol <= we_ready_viol + 1;
      if (!prev_hs)       we_latency_viol <= we_latency_viol + 1;
    end
    if (bus.byte_valid && bus.byte_ready) hs_count <= hs_count + 1;
    prev_hs <= bus.byte_valid && bus.byte_ready;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Entered and left at 1 time unit after a rising edge; leaves byte_valid high.
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    for (int i = 0; i < gap; i++) begin
      bus.byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (bus.byte_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Reference model: interprets the byte stream directly.
  task automatic model(input bq_t s, output int consumed, output bit m_done, output bit m_err);
    int          n;
    logic [7:0]  x;
    logic [31:0] w;
    exp_q.delete();
    n = {s[0], s[1]};
    m_done = 1'b0;
    m_err  = 1'b0;
    if (n > CAP) begin
      consumed = 2;
      m_err    = 1'b1;
    end else begin
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
        w = {s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]};
        x = x ^ s[2+4*k] ^ s[3+4*k] ^ s[4+4*k] ^ s[5+4*k];
        exp_q.push_back({ADDR_W'(k), w});
      end
      consumed = 3 + 4 * n;
      if (s[2+4*n] == x) m_done = 1'b1;
      else               m_err  = 1'b1;
    end
  endtask

  function automatic bq_t build(input int n, input bit bad);
    bq_t        s;
    logic [7:0] b;
    logic [7:0] x = 8'h00;
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    if (n <= CAP) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom_range(0, 255));
        x = x ^ b;
        s.push_back(b);
      end
      s.push_back(bad ? (x ^ 8'h5A) : x);
    end
    return s;
  endfunction

  int base_wr;
  bit last_done;
  bit last_err;

  task automatic run_session(input string name, input bq_t s, input int max_gap);
    int consumed;
    int base_hs, base_rv, base_lv;
    bit ok;
    bit m_done, m_err;
    model(s, consumed, m_done, m_err);
    base_wr = wr_log.size();
    base_hs = hs_count;
    base_rv = we_ready_viol;
    base_lv = we_latency_viol;
    pulse_start();
    for (int i = 0; i < consumed; i++) begin
      send_byte(s[i], $urandom_range(0, max_gap), ok);
      if (!ok) begin
        check({name, " byte accept timeout"}, 64'd0, 64'd1);
        break;
      end
    end
    bus.byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({name, " write count"}, 64'(wr_log.size() - base_wr), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && base_wr + k < wr_log.size(); k++)
      check({name, " write"}, 64'(wr_log[base_wr+k]), 64'(exp_q[k]));
    check({name, " bytes accepted"}, 64'(hs_count - base_hs), 64'(consumed));
    check({name, " ready during write"}, 64'(we_ready_viol - base_rv), 64'd0);
    check({name, " write latency"}, 64'(we_latency_viol - base_lv), 64'd0);
    check({name, " done"}, 64'(bus.done), 64'(m_done));
    check({name, " error"}, 64'(bus.error), 64'(m_err));
    check({name, " cpu_hold"}, 64'(bus.cpu_hold), 64'(!m_done));
    check({name, " byte_ready idle"}, 64'(bus.byte_ready), 64'd0);
    last_done = bus.done;
    last_err  = bus.error;
  endtask

  vec_t vecs[7];
  bq_t  s;
  bit   ok;

  initial begin
    vecs[0] = '{n: 1,    bad: 1'b0, max_gap: 2, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{n: 3,    bad: 1'b0, max_gap: 3, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{n: 2,    bad: 1'b1, max_gap: 1, exp_done: 1'b0, exp_err: 1'b1};
    vecs[3] = '{n: 0,    bad: 1'b0, max_gap: 2, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{n: 0,    bad: 1'b1, max_gap: 0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[5] = '{n: 1025, bad: 1'b0, max_gap: 1, exp_done: 1'b0, exp_err: 1'b1};
    vecs[6] = '{n: 1024, bad: 1'b0, max_gap: 0, exp_done: 1'b1, exp_err: 1'b0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset byte_ready", 64'(bus.byte_ready), 64'd0);
    check("reset im_we", 64'(bus.im_we), 64'd0);
    check("reset cpu_hold", 64'(bus.cpu_hold), 64'd1);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset error", 64'(bus.error), 64'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle after reset state", 64'(state), 64'd0);
    check("idle after reset ready", 64'(bus.byte_ready), 64'd0);

    // Two-word reference load; the XOR of its eight data bytes is 0x3A.
    s = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'h00, 8'h22, 8'h18, 8'h20, 8'h3A};
    run_session("two-word good", s, 1);
    if (wr_log.size() >= base_wr + 2) begin
      check("two-word addr0", 64'(wr_log[base_wr]), 64'({10'd0, 32'h24010005}));
      check("two-word addr1", 64'(wr_log[base_wr+1]), 64'({10'd1, 32'h00221820}));
    end else begin
      check("two-word writes present", 64'(wr_log.size() - base_wr), 64'd2);
    end
    check("two-word done", 64'(last_done), 64'd1);
    check("hold im_addr", 64'(bus.im_addr), 64'd1);
    check("hold im_wdata", 64'(bus.im_wdata), 64'h00221820);

    s[10] = 8'h00;
    run_session("two-word bad csum", s, 0);
    check("bad csum writes", 64'(wr_log.size() - base_wr), 64'd2);
    check("bad csum error", 64'(last_err), 64'd1);

    s = '{8'h00, 8'h00, 8'h00};
    run_session("empty load", s, 0);
    check("empty load done", 64'(last_done), 64'd1);

    s = '{8'h04, 8'h01};
    run_session("oversize count", s, 0);
    check("oversize error", 64'(last_err), 64'd1);

    // Continuous byte_valid across a one-word load
    s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    run_session("continuous valid", s, 0);
    check("continuous valid done", 64'(last_done), 64'd1);

    for (int v = 0; v < 7; v++) begin
      s = build(vecs[v].n, vecs[v].bad);
      run_session($sformatf("vec%0d", v), s, vecs[v].max_gap);
      check($sformatf("vec%0d table done", v), 64'(last_done), 64'(vecs[v].exp_done));
      check($sformatf("vec%0d table error", v), 64'(last_err), 64'(vecs[v].exp_err));
    end

    // Reset after the third data byte of a word
    pulse_start();
    s = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 5; i++) begin
      send_byte(s[i], 0, ok);
      if (!ok) check("mid-reset byte accept timeout", 64'd0, 64'd1);
    end
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid-reset state", 64'(state), 64'd0);
    check("mid-reset byte_ready", 64'(bus.byte_ready), 64'd0);
    check("mid-reset im_we", 64'(bus.im_we), 64'd0);
    check("mid-reset im_addr", 64'(bus.im_addr), 64'd0);
    check("mid-reset im_wdata", 64'(bus.im_wdata), 64'd0);
    check("mid-reset cpu_hold", 64'(bus.cpu_hold), 64'd1);
    check("mid-reset done", 64'(bus.done), 64'd0);
    check("mid-reset error", 64'(bus.error), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("post-reset stays idle", 64'(state), 64'd0);
    s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    run_session("reload after reset", s, 2);
    if (wr_log.size() > base_wr)
      check("reload addr0", 64'(wr_log[base_wr]), 64'({10'd0, 32'h12345678}));
    check("reload done", 64'(last_done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
